// File: rtl/trace_buffer_drain_if.sv
// Capture-side result stream and drain-side readout stream of the trace buffer.
// Drain handshake: an entry transfers on a posedge where drain_valid and drain_ready are both 1;
// while drain_valid=1 and drain_ready=0 the entry fields hold steady, and drain_valid never waits on drain_ready.
interface trace_buffer_drain_if #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int CHAIN_W    = 2
);
    logic                           valid_in;
    logic [1:0]                     eof_in;
    logic [1:0]                     bof_in;
    logic [CHAIN_W-1:0]             chainId_in;
    logic [N-1:0][DATA_WIDTH-1:0]   vector_in;

    logic                           drain_ready;
    logic                           drain_valid;
    logic [N-1:0][DATA_WIDTH-1:0]   drain_vector;
    logic [CHAIN_W-1:0]             drain_chainId;
    logic [3:0]                     drain_flags;
    logic                           drain_last;

    modport master (
        output valid_in, eof_in, bof_in, chainId_in, vector_in, drain_ready,
        input  drain_valid, drain_vector, drain_chainId, drain_flags, drain_last
    );

    modport slave (
        input  valid_in, eof_in, bof_in, chainId_in, vector_in, drain_ready,
        output drain_valid, drain_vector, drain_chainId, drain_flags, drain_last
    );
endinterface

// File: rtl/trace_buffer_drain.sv
// Circular trace buffer: captures ALU result vectors while tracing, drains them oldest-first afterwards.
// Capture mask and wrap/stop policy are loaded over the shared configId/configData byte bus.
module trace_buffer_drain #(
    parameter int N                  = 8,
    parameter int DATA_WIDTH         = 32,
    parameter int MAX_CHAINS         = 4,
    parameter int TB_SIZE            = 16,
    parameter int PERSONAL_CONFIG_ID = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tracing,
    input  logic [7:0]                configId,
    input  logic [7:0]                configData,
    trace_buffer_drain_if.slave       bus,
    output logic [$clog2(TB_SIZE):0]  fill_level,
    output logic                      overflow,
    output logic [1:0]                dbg_state
);
    localparam int PTR_W   = $clog2(TB_SIZE);
    localparam int LVL_W   = PTR_W + 1;
    localparam int CHAIN_W = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(TB_SIZE);
    localparam logic [7:0]       MY_ID    = 8'(PERSONAL_CONFIG_ID);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t                   state, state_next;
    logic [PTR_W-1:0]         wr_ptr, rd_ptr;
    logic [LVL_W-1:0]         level, level_next;
    logic                     cfg_stop;
    logic [MAX_CHAINS-1:0]    cfg_mask;
    logic [1:0]               byte_counter;

    logic [N-1:0][DATA_WIDTH-1:0] mem_vec   [TB_SIZE];
    logic [CHAIN_W-1:0]           mem_chain [TB_SIZE];
    logic [3:0]                   mem_flags [TB_SIZE];

    logic cfg_sel, cfg_clear, write_req, is_full, do_write, do_drop, drain_valid, do_pop;
    logic cfg_byte_unused;

    assign cfg_sel     = ~tracing & (configId == MY_ID);
    assign cfg_clear   = cfg_sel & (byte_counter == 2'd0) & configData[1];
    assign write_req   = tracing & bus.valid_in & cfg_mask[bus.chainId_in];
    assign is_full     = (level == LVL_FULL);
    // When full in wrap mode the write lands on the oldest slot (wr_ptr == rd_ptr).
    assign do_write    = write_req & (~is_full | ~cfg_stop);
    assign do_drop     = write_req & is_full;
    assign drain_valid = (state == ST_DRAIN) & ~tracing & (level != '0);
    assign do_pop      = drain_valid & bus.drain_ready;
    assign cfg_byte_unused = ^configData;

    always_comb begin
        level_next = level;
        state_next = state;
        if (cfg_clear)
            level_next = '0;
        else if (do_write && !is_full)
            level_next = level + 1'b1;
        else if (do_pop)
            level_next = level - 1'b1;

        if (tracing)
            state_next = ST_CAPTURE;
        else if (state != ST_EMPTY)
            state_next = (level_next != '0) ? ST_DRAIN : ST_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_EMPTY;
            level        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            overflow     <= 1'b0;
            cfg_stop     <= 1'b0;
            cfg_mask     <= '1;
            byte_counter <= 2'd0;
        end else begin
            state <= state_next;
            level <= level_next;
            if (cfg_clear) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                overflow <= 1'b0;
            end else begin
                if (do_write)
                    wr_ptr <= wr_ptr + 1'b1;
                if ((do_write && is_full) || do_pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (do_drop)
                    overflow <= 1'b1;
            end
            // Config bytes are counted only in the drain/config phase; tracing freezes the counter.
            if (cfg_sel) begin
                if (byte_counter == 2'd0)
                    cfg_stop <= configData[0];
                if (byte_counter == 2'd1)
                    cfg_mask <= configData[MAX_CHAINS-1:0];
                if (byte_counter != 2'd2)
                    byte_counter <= byte_counter + 1'b1;
            end else if (!tracing) begin
                byte_counter <= 2'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_write) begin
            mem_vec[wr_ptr]   <= bus.vector_in;
            mem_chain[wr_ptr] <= bus.chainId_in;
            mem_flags[wr_ptr] <= {bus.eof_in, bus.bof_in};
        end
    end

    assign bus.drain_valid   = drain_valid;
    assign bus.drain_vector  = drain_valid ? mem_vec[rd_ptr]   : '0;
    assign bus.drain_chainId = drain_valid ? mem_chain[rd_ptr] : '0;
    assign bus.drain_flags   = drain_valid ? mem_flags[rd_ptr] : '0;
    assign bus.drain_last    = drain_valid & (level == LVL_W'(1));
    assign fill_level        = level;
    assign dbg_state         = state;
endmodule

// File: tb/tb_trace_buffer_drain.sv
// Bench for trace_buffer_drain: directed scenarios plus random capture/drain/config traffic,
// all scored against a queue model of the trace buffer.
module tb_trace_buffer_drain;
    localparam int N          = 8;
    localparam int DW         = 32;
    localparam int MAX_CHAINS = 4;
    localparam int TB_SIZE    = 16;
    localparam int CHAIN_W    = 2;
    localparam int LVL_W      = 5;
    localparam int ENTRY_W    = N * DW + CHAIN_W + 4;
    localparam logic [7:0] CFG_ID  = 8'h00;
    localparam logic [7:0] IDLE_ID = 8'hFF;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst_n;
    logic             tracing;
    logic [7:0]       configId, configData;
    logic [LVL_W-1:0] fill_level;
    logic             overflow;
    logic [1:0]       dbg_state;

    always #5 clk = ~clk;

    trace_buffer_drain_if #(.N(N), .DATA_WIDTH(DW), .CHAIN_W(CHAIN_W)) bus ();

    trace_buffer_drain #(
        .N(N), .DATA_WIDTH(DW), .MAX_CHAINS(MAX_CHAINS), .TB_SIZE(TB_SIZE), .PERSONAL_CONFIG_ID(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tracing(tracing),
        .configId(configId), .configData(configData),
        .bus(bus),
        .fill_level(fill_level), .overflow(overflow), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard / reference model ----------------
    logic [ENTRY_W-1:0] exp_q[$];
    logic               m_ovf;
    logic               m_stop;
    logic [3:0]         m_mask;
    int                 m_cnt;
    logic               m_tr_prev;
    int                 n_checks = 0;
    int                 n_fail   = 0;

    task automatic check(input string tag, input logic [ENTRY_W-1:0] got, input logic [ENTRY_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [ENTRY_W-1:0] drain_bundle();
        return {bus.drain_vector, bus.drain_chainId, bus.drain_flags};
    endfunction

    // One clock of stimulus: drive, check outputs against the model, advance the model at the edge.
    task automatic cycle(input logic tr, input logic vin, input int cid, input logic [DW-1:0] lane0,
                         input logic [7:0] cfg_id, input logic [7:0] cfg_data, input logic rdy);
        logic [N-1:0][DW-1:0] vec;
        logic [3:0]           flg;
        logic                 exp_valid;
        logic                 clr;
        logic [ENTRY_W-1:0]   ent;
        vec[0] = lane0;
        for (int l = 1; l < N; l++) vec[l] = $urandom;
        flg = 4'($urandom);
        ent = {vec, CHAIN_W'(cid), flg};
        tracing         = tr;
        bus.valid_in    = vin;
        bus.chainId_in  = CHAIN_W'(cid);
        bus.vector_in   = vec;
        bus.eof_in      = flg[3:2];
        bus.bof_in      = flg[1:0];
        bus.drain_ready = rdy;
        configId        = cfg_id;
        configData      = cfg_data;
        #1;
        // An entry is offered once tracing has been low for a full cycle and something is stored.
        exp_valid = !m_tr_prev && !tr && (exp_q.size() > 0);
        check("drain_valid", ENTRY_W'(bus.drain_valid), ENTRY_W'(exp_valid));
        check("drain_last", ENTRY_W'(bus.drain_last), ENTRY_W'(exp_valid && exp_q.size() == 1));
        if (exp_valid) check("drain_entry", drain_bundle(), exp_q[0]);
        check("fill_level", ENTRY_W'(fill_level), ENTRY_W'(exp_q.size()));
        check("overflow", ENTRY_W'(overflow), ENTRY_W'(m_ovf));
        @(posedge clk);
        clr = 1'b0;
        if (tr) begin
            if (vin && m_mask[cid]) begin
                if (exp_q.size() < TB_SIZE) exp_q.push_back(ent);
                else if (!m_stop) begin
                    void'(exp_q.pop_front());
                    exp_q.push_back(ent);
                    m_ovf = 1'b1;
                end else m_ovf = 1'b1;
            end
        end else begin
            if (cfg_id == CFG_ID) begin
                if (m_cnt == 0) begin
                    m_stop = cfg_data[0];
                    clr    = cfg_data[1];
                end else if (m_cnt == 1) m_mask = cfg_data[3:0];
                if (m_cnt < 2) m_cnt++;
            end else m_cnt = 0;
            if (clr) begin
                exp_q.delete();
                m_ovf = 1'b0;
            end else if (exp_valid && rdy) void'(exp_q.pop_front());
        end
        m_tr_prev = tr;
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input logic rdy);
        cycle(1'b0, 1'b0, 0, '0, IDLE_ID, 8'h00, rdy);
    endtask

    task automatic capture(input int cid, input logic [DW-1:0] lane0);
        cycle(1'b1, 1'b1, cid, lane0, IDLE_ID, 8'h00, 1'b0);
    endtask

    task automatic cfg_byte(input logic [7:0] data);
        cycle(1'b0, 1'b0, 0, '0, CFG_ID, data, 1'b0);
    endtask

    task automatic drain_all(input logic random_ready);
        for (int k = 0; k < 200 && exp_q.size() > 0; k++)
            idle(random_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        check("drain_done_level", ENTRY_W'(fill_level), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [ENTRY_W-1:0] snap;
        logic               ph;
        logic [7:0]         d;

        exp_q.delete();
        m_ovf = 1'b0; m_stop = 1'b0; m_mask = 4'hF; m_cnt = 0; m_tr_prev = 1'b1;

        // reset with capture traffic present
        rst_n = 1'b0; tracing = 1'b1; bus.valid_in = 1'b1; bus.chainId_in = '0;
        bus.vector_in = '1; bus.eof_in = 2'b11; bus.bof_in = 2'b11; bus.drain_ready = 1'b1;
        configId = IDLE_ID; configData = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; tracing = 1'b0; bus.valid_in = 1'b0;
        #1;
        check("reset_level", ENTRY_W'(fill_level), '0);
        check("reset_overflow", ENTRY_W'(overflow), '0);
        check("reset_drain_valid", ENTRY_W'(bus.drain_valid), '0);
        check("reset_drain_fields", drain_bundle(), '0);

        // basic: three vectors on chains 0..2, drained in order
        for (int i = 0; i < 3; i++) capture(i, DW'(i + 1));
        check("basic_level", ENTRY_W'(fill_level), ENTRY_W'(3));
        drain_all(1'b0);

        // wrap policy: 20 captures keep the newest 16
        for (int i = 0; i < 20; i++) capture($urandom_range(0, 3), DW'(i));
        check("wrap_level", ENTRY_W'(fill_level), ENTRY_W'(16));
        check("wrap_overflow", ENTRY_W'(overflow), ENTRY_W'(1));
        drain_all(1'b0);
        check("overflow_sticky", ENTRY_W'(overflow), ENTRY_W'(1));
        cfg_byte(8'h02);
        idle(1'b0);
        check("clear_overflow", ENTRY_W'(overflow), '0);

        // stop policy: 20 captures keep the oldest 16
        cfg_byte(8'h01);
        idle(1'b0);
        for (int i = 0; i < 20; i++) capture($urandom_range(0, 3), DW'(i));
        check("stop_level", ENTRY_W'(fill_level), ENTRY_W'(16));
        check("stop_overflow", ENTRY_W'(overflow), ENTRY_W'(1));
        drain_all(1'b1);
        cfg_byte(8'h02);
        idle(1'b0);

        // mask 0101, backpressure, ignored third config byte
        cfg_byte(8'h02);
        cfg_byte(8'h05);
        idle(1'b0);
        for (int i = 0; i < 8; i++) capture(i % 4, DW'(100 + i));
        check("mask_level", ENTRY_W'(fill_level), ENTRY_W'(4));
        idle(1'b0);
        snap = drain_bundle();
        for (int i = 0; i < 5; i++) begin
            idle(1'b0);
            check("stall_hold", drain_bundle(), snap);
        end
        check("stall_level", ENTRY_W'(fill_level), ENTRY_W'(4));
        cfg_byte(8'h00);
        cfg_byte(8'h05);
        cfg_byte(8'h02);
        check("cfg_saturate_level", ENTRY_W'(fill_level), ENTRY_W'(4));
        idle(1'b0);
        drain_all(1'b1);
        cfg_byte(8'h02);
        cfg_byte(8'h0F);
        idle(1'b0);

        // drain abort: tracing rises after two pops, then append, then clear mid-drain
        for (int i = 0; i < 5; i++) capture($urandom_range(0, 3), DW'(200 + i));
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        cycle(1'b1, 1'b0, 0, '0, IDLE_ID, 8'h00, 1'b1);
        check("abort_level", ENTRY_W'(fill_level), ENTRY_W'(3));
        capture(1, DW'(300));
        capture(3, DW'(301));
        idle(1'b0);
        idle(1'b1);
        check("append_level", ENTRY_W'(fill_level), ENTRY_W'(4));
        cycle(1'b0, 1'b0, 0, '0, CFG_ID, 8'h02, 1'b1);
        check("clear_drain_valid", ENTRY_W'(bus.drain_valid), '0);
        check("clear_level", ENTRY_W'(fill_level), '0);
        check("clear_overflow2", ENTRY_W'(overflow), '0);
        idle(1'b0);

        // random traffic
        ph = 1'b1;
        for (int c = 0; c < 700; c++) begin
            if ($urandom_range(0, 9) == 0) ph = ~ph;
            d = 8'($urandom);
            if ($urandom_range(0, 7) != 0) d[1] = 1'b0;
            cycle(ph, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom,
                  ($urandom_range(0, 5) == 0) ? CFG_ID : IDLE_ID, d, 1'($urandom_range(0, 1)));
        end
        idle(1'b0);
        drain_all(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
